// File: rtl/thread_pc_unit_pkg.sv
// Shared constants and types for the multi-threaded fetch PC unit.
package thread_pc_unit_pkg;

    localparam int unsigned PC_W           = 32;
    localparam int unsigned NUM_THREAD_DEF = 4;
    localparam logic [PC_W-1:0] HANDLER    = 32'h0000_1000;

    // Thread-id width for a given thread count (at least one bit).
    function automatic int unsigned tid_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned TID_W = tid_width(NUM_THREAD_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } thread_state_e;

endpackage

// File: rtl/thread_pc_unit_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping around.
module rr_arbiter
    import thread_pc_unit_pkg::*;
#(
    parameter int unsigned N = NUM_THREAD_DEF,
    localparam int unsigned TW = tid_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic [N-1:0]  grant_c,
    output logic          valid_c
);

    logic [TW-1:0] idx;

    // N is a power of two, so truncating to TW bits is the modulo-N wrap.
    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        idx     = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = TW'(32'(ptr) + i);
            if (!valid_c && req[idx]) begin
                grant_c[idx] = 1'b1;
                valid_c      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_pc_unit.sv
// Per-thread PC/state registers with round-robin fetch selection and
// kill > exception > jump > start > increment update priority.
module thread_pc_unit
    import thread_pc_unit_pkg::*;
#(
    parameter int unsigned NUM_THREAD = NUM_THREAD_DEF,
    localparam int unsigned TW = tid_width(NUM_THREAD)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  jmp_en,
    input  logic [PC_W-1:0]       jmp_pc,
    input  logic [TW-1:0]         jmp_tid,
    input  logic                  exc,
    input  logic [TW-1:0]         exc_tid,
    input  logic                  start_vld,
    input  logic [TW-1:0]         start_tid,
    input  logic [PC_W-1:0]       start_pc,
    input  logic                  kill_vld,
    input  logic [TW-1:0]         kill_tid,
    output logic                  fetch_vld,
    output logic [PC_W-1:0]       fetch_pc,
    output logic [TW-1:0]         fetch_tid,
    output logic [NUM_THREAD-1:0] active
);

    thread_state_e         state_q [NUM_THREAD];
    thread_state_e         state_d [NUM_THREAD];
    logic [PC_W-1:0]       pc_q    [NUM_THREAD];
    logic [PC_W-1:0]       pc_d    [NUM_THREAD];
    logic [TW-1:0]         rr_ptr_q;
    logic [TW-1:0]         rr_ptr_d;
    logic [NUM_THREAD-1:0] run_vec;
    logic [NUM_THREAD-1:0] grant_c;
    logic                  grant_vld_c;
    logic [TW-1:0]         sel_tid_c;
    logic                  accept_c;

    always_comb begin
        run_vec = '0;
        for (int unsigned t = 0; t < NUM_THREAD; t++) begin
            run_vec[t] = (state_q[t] == RUN);
        end
    end

    assign active = run_vec;

    rr_arbiter #(.N(NUM_THREAD)) u_arb (
        .req     (run_vec),
        .ptr     (rr_ptr_q),
        .grant_c (grant_c),
        .valid_c (grant_vld_c)
    );

    // One-hot grant to thread index.
    always_comb begin
        sel_tid_c = '0;
        for (int unsigned t = 0; t < NUM_THREAD; t++) begin
            if (grant_c[t]) begin
                sel_tid_c = TW'(t);
            end
        end
    end

    assign fetch_vld = grant_vld_c;
    assign fetch_tid = grant_vld_c ? sel_tid_c : '0;
    assign fetch_pc  = grant_vld_c ? pc_q[sel_tid_c] : '0;
    assign accept_c  = grant_vld_c & ~stall;

    // Later assignments win, so the order below encodes the per-thread priority.
    always_comb begin
        rr_ptr_d = accept_c ? sel_tid_c : rr_ptr_q;
        for (int unsigned t = 0; t < NUM_THREAD; t++) begin
            pc_d[t]    = pc_q[t];
            state_d[t] = state_q[t];
            if (accept_c && sel_tid_c == TW'(t)) begin
                pc_d[t] = pc_q[t] + 32'd1;
            end
            if (start_vld && start_tid == TW'(t) && state_q[t] == IDLE) begin
                state_d[t] = RUN;
                pc_d[t]    = start_pc;
            end
            if (jmp_en && jmp_tid == TW'(t) && state_q[t] == RUN) begin
                pc_d[t] = jmp_pc;
            end
            if (exc && exc_tid == TW'(t) && state_q[t] == RUN) begin
                pc_d[t] = HANDLER;
            end
            if (kill_vld && kill_tid == TW'(t)) begin
                state_d[t] = IDLE;
            end
        end
    end

    // Thread 0 comes out of reset running; rr_ptr points at the last thread
    // so thread 0 wins the first grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < NUM_THREAD; t++) begin
                pc_q[t]    <= '0;
                state_q[t] <= IDLE;
            end
            state_q[0] <= RUN;
            rr_ptr_q   <= TW'(NUM_THREAD - 1);
        end else begin
            for (int unsigned t = 0; t < NUM_THREAD; t++) begin
                pc_q[t]    <= pc_d[t];
                state_q[t] <= state_d[t];
            end
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_thread_pc_unit.sv
// Directed and randomized bench for thread_pc_unit against a behavioural model.
module tb_thread_pc_unit;

    localparam int unsigned NT      = 4;
    localparam int unsigned TW      = 2;
    localparam logic [31:0] HANDLER = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          jmp_en;
    logic [31:0]   jmp_pc;
    logic [TW-1:0] jmp_tid;
    logic          exc;
    logic [TW-1:0] exc_tid;
    logic          start_vld;
    logic [TW-1:0] start_tid;
    logic [31:0]   start_pc;
    logic          kill_vld;
    logic [TW-1:0] kill_tid;
    logic          fetch_vld;
    logic [31:0]   fetch_pc;
    logic [TW-1:0] fetch_tid;
    logic [NT-1:0] active;

    int checks   = 0;
    int failures = 0;

    // Reference state: PCs, run flags and the last granted thread.
    logic [31:0] m_pc  [NT];
    bit          m_run [NT];
    int          m_last;

    thread_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp_en    (jmp_en),
        .jmp_pc    (jmp_pc),
        .jmp_tid   (jmp_tid),
        .exc       (exc),
        .exc_tid   (exc_tid),
        .start_vld (start_vld),
        .start_tid (start_tid),
        .start_pc  (start_pc),
        .kill_vld  (kill_vld),
        .kill_tid  (kill_tid),
        .fetch_vld (fetch_vld),
        .fetch_pc  (fetch_pc),
        .fetch_tid (fetch_tid),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_pc[t]  = 32'd0;
            m_run[t] = (t == 0);
        end
        m_last = NT - 1;
    endtask

    // Next running thread after the last granted one, scanning in thread order.
    task automatic model_sel(output bit v, output int tid);
        v   = 1'b0;
        tid = 0;
        for (int k = 1; k <= NT; k++) begin
            if (!v && m_run[(m_last + k) % NT]) begin
                v   = 1'b1;
                tid = (m_last + k) % NT;
            end
        end
    endtask

    task automatic model_step();
        bit          v;
        int          t;
        logic [31:0] npc  [NT];
        bit          nrun [NT];
        if (rst) begin
            model_reset();
            return;
        end
        model_sel(v, t);
        npc  = m_pc;
        nrun = m_run;
        if (v && !stall) begin
            npc[t] = m_pc[t] + 32'd1;
            m_last = t;
        end
        if (start_vld && !m_run[start_tid]) begin
            nrun[start_tid] = 1'b1;
            npc[start_tid]  = start_pc;
        end
        if (jmp_en && m_run[jmp_tid]) npc[jmp_tid] = jmp_pc;
        if (exc && m_run[exc_tid])    npc[exc_tid] = HANDLER;
        if (kill_vld)                 nrun[kill_tid] = 1'b0;
        m_pc  = npc;
        m_run = nrun;
    endtask

    task automatic check_all(input string tag);
        bit          v;
        int          t;
        logic [31:0] act;
        model_sel(v, t);
        act = '0;
        for (int i = 0; i < NT; i++) act[i] = m_run[i];
        chk({tag, ".vld"},    32'(fetch_vld), 32'(v));
        chk({tag, ".pc"},     fetch_pc,       v ? m_pc[t] : 32'd0);
        chk({tag, ".tid"},    32'(fetch_tid), v ? 32'(t) : 32'd0);
        chk({tag, ".active"}, 32'(active),    act);
    endtask

    task automatic clear_pulses();
        jmp_en    = 1'b0;
        exc       = 1'b0;
        start_vld = 1'b0;
        kill_vld  = 1'b0;
    endtask

    // Check outputs, clock the DUT and the model together, drop one-shot inputs.
    task automatic cyc(input string tag);
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
        clear_pulses();
    endtask

    task automatic rand_inputs();
        stall     = ($urandom % 4) == 0;
        jmp_en    = ($urandom % 5) == 0;
        jmp_tid   = TW'($urandom);
        jmp_pc    = $urandom;
        exc       = ($urandom % 11) == 0;
        exc_tid   = TW'($urandom);
        start_vld = ($urandom % 4) == 0;
        start_tid = TW'($urandom);
        start_pc  = (($urandom % 8) == 0) ? 32'hFFFF_FFFF : $urandom;
        kill_vld  = ($urandom % 9) == 0;
        kill_tid  = TW'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        jmp_pc = '0; jmp_tid = '0; exc_tid = '0;
        start_tid = '0; start_pc = '0; kill_tid = '0;
        clear_pulses();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 32'(fetch_vld), 32'd1);
        chk("rst.pc", fetch_pc, 32'd0);
        chk("rst.tid", 32'(fetch_tid), 32'd0);
        chk("rst.active", 32'(active), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            chk("seq.pc", fetch_pc, 32'(i));
            chk("seq.tid", 32'(fetch_tid), 32'd0);
            cyc("seq");
        end
        cyc("adv");
        cyc("adv");

        // Start thread 1 while thread 0 fetches pc 5; fetches then alternate.
        chk("alt0.pc", fetch_pc, 32'd5);
        start_vld = 1'b1; start_tid = 2'd1; start_pc = 32'h100;
        cyc("alt0");
        chk("alt1.pc", fetch_pc, 32'h100);
        chk("alt1.tid", 32'(fetch_tid), 32'd1);
        cyc("alt1");
        chk("alt2.pc", fetch_pc, 32'd6);
        chk("alt2.tid", 32'(fetch_tid), 32'd0);
        cyc("alt2");
        chk("alt3.pc", fetch_pc, 32'h101);
        cyc("alt3");

        // Jump on the accepted thread overrides its increment.
        chk("jmp.pc", fetch_pc, 32'd7);
        jmp_en = 1'b1; jmp_tid = 2'd0; jmp_pc = 32'h40;
        cyc("jmp");
        cyc("jmp.t1");
        chk("jmp.tgt", fetch_pc, 32'h40);
        chk("jmp.tid", 32'(fetch_tid), 32'd0);
        cyc("jmp.tgt");

        // Exception beats jump on thread 1; then kill beats exception.
        stall = 1'b1;
        exc = 1'b1; exc_tid = 2'd1;
        jmp_en = 1'b1; jmp_tid = 2'd1; jmp_pc = 32'h200;
        cyc("exc");
        stall = 1'b0;
        chk("exc.pc", fetch_pc, HANDLER);
        chk("exc.tid", 32'(fetch_tid), 32'd1);
        kill_vld = 1'b1; kill_tid = 2'd1;
        exc = 1'b1; exc_tid = 2'd1;
        cyc("kill1");
        chk("kill1.active", 32'(active), 32'h1);
        chk("kill1.pc", fetch_pc, 32'h41);

        // Stall holds everything; 0xFFFFFFFF wraps to 0.
        start_vld = 1'b1; start_tid = 2'd2; start_pc = 32'hFFFF_FFFF;
        cyc("st2");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stall.pc", fetch_pc, 32'hFFFF_FFFF);
            chk("stall.tid", 32'(fetch_tid), 32'd2);
            cyc("stall");
        end
        stall = 1'b0;
        cyc("wrap.acc");
        chk("wrap.t0", fetch_pc, 32'h42);
        cyc("wrap.t0");
        chk("wrap.pc", fetch_pc, 32'd0);
        chk("wrap.tid", 32'(fetch_tid), 32'd2);

        // Kill all; killing the selected thread leaves this cycle's outputs alone.
        kill_vld = 1'b1; kill_tid = 2'd0;
        cyc("killa");
        kill_vld = 1'b1; kill_tid = 2'd2;
        chk("killsel.pc", fetch_pc, 32'd1);
        cyc("killsel");
        chk("dead.vld", 32'(fetch_vld), 32'd0);
        chk("dead.pc", fetch_pc, 32'd0);
        chk("dead.active", 32'(active), 32'd0);
        cyc("dead");

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cyc("rnd");
        end

        // Asynchronous reset in the middle of a cycle with events pending.
        rand_inputs();
        start_vld = 1'b1;
        kill_vld  = 1'b1;
        jmp_en    = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst.vld", 32'(fetch_vld), 32'd1);
        chk("arst.pc", fetch_pc, 32'd0);
        chk("arst.tid", 32'(fetch_tid), 32'd0);
        chk("arst.active", 32'(active), 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst2.pc", fetch_pc, 32'd0);
        chk("arst2.active", 32'(active), 32'h1);
        rst = 1'b0;
        stall = 1'b0;
        clear_pulses();
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            cyc("post");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
